// File: rtl/jk_excitation_driver_if.sv
// Handshake and excitation bus between a requester, the jk_excitation_driver
// and the external JK flip-flop bank it drives.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, target, q_fb,
    input  J, K, busy, done, err
  );

  modport slave (
    input  start, target, q_fb,
    output J, K, busy, done, err
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK bank toward a latched target, verifies the bank via q_fb
// and retries up to MAX_RETRY times. Macro JK_TOGGLE_EXCITE_EN selects toggle-form excitation.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input logic                   CLK,
  input logic                   CLR,
  jk_excitation_driver_if.slave bus
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Per-bit JK excitation table; returns {J, K}. Hold bits never get J=K=1.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] nxt);
`ifdef JK_TOGGLE_EXCITE_EN
    excite = {cur | nxt, ~(cur & nxt)};
`else
    excite = {~cur & nxt, cur & ~nxt};
`endif
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] tgt_r, tgt_s;
  logic [RW-1:0]    retry_r, retry_s;
  logic [WIDTH-1:0] j_r, j_s;
  logic [WIDTH-1:0] k_r, k_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    tgt_s   = tgt_r;
    retry_s = retry_r;
    j_s     = {WIDTH{1'b0}};
    k_s     = {WIDTH{1'b0}};
    done_s  = 1'b0;
    err_s   = err_r;
    case (state_r)
      IDLE, ERROR: begin
        if (bus.start) begin
          tgt_s      = bus.target;
          retry_s    = {RW{1'b0}};
          err_s      = 1'b0;
          state_s    = DRIVE;
          {j_s, k_s} = excite(bus.q_fb, bus.target);
        end else begin
          state_s = state_r;
        end
      end
      DRIVE: begin
        state_s = CHECK;
      end
      CHECK: begin
        if (bus.q_fb == tgt_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (retry_r < RETRY_LIMIT) begin
          retry_s    = retry_r + RW'(1'b1);
          state_s    = DRIVE;
          {j_s, k_s} = excite(bus.q_fb, tgt_r);
        end else begin
          state_s = ERROR;
          err_s   = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == DRIVE) || (state_s == CHECK);
  end

  // State and registered outputs; CLR aborts any drive in progress.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r <= IDLE;
      tgt_r   <= {WIDTH{1'b0}};
      retry_r <= {RW{1'b0}};
      j_r     <= {WIDTH{1'b0}};
      k_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      tgt_r   <= tgt_s;
      retry_r <= retry_s;
      j_r     <= j_s;
      k_r     <= k_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign bus.J    = j_r;
  assign bus.K    = k_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed table-driven bench for jk_excitation_driver with a behavioural JK bank model
// that can ignore drives or hold bit 0 stuck at 0.
module tb_jk_excitation_driver;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   tests = 0;
  int   fails = 0;

  jk_excitation_driver_if #(.WIDTH(4)) bus ();

  jk_excitation_driver #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Bank model: independent JK flip-flops, with drive-skip and stuck-at-0 fault injection.
  logic [3:0] q_bank      = 4'b0000;
  logic [3:0] stuck       = 4'b0000;
  int         drive_cnt   = 0;
  int         skip_until  = 0;

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (|(bus.J | bus.K)) begin
      drive_cnt <= drive_cnt + 1;
      if (drive_cnt >= skip_until) q_bank <= jk_next(q_bank, bus.J, bus.K) & ~stuck;
    end
  end

  assign bus.q_fb = q_bank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] target;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
    int         skip;
    logic [3:0] stuck;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];
  int   lat;
  int   done_cnt;
  int   done_at;

  initial begin
`ifdef JK_TOGGLE_EXCITE_EN
    vecs[0] = '{4'b1010, 4'b1010, 4'b1111, 0, 4'b0000, 2, 1'b0};
    vecs[1] = '{4'b0110, 4'b1110, 4'b1101, 0, 4'b0000, 2, 1'b0};
    vecs[2] = '{4'b0110, 4'b0110, 4'b1001, 0, 4'b0000, 2, 1'b0};
    vecs[3] = '{4'b1000, 4'b1110, 4'b1111, 1, 4'b0000, 4, 1'b0};
    vecs[4] = '{4'b0001, 4'b1001, 4'b1111, 0, 4'b0001, 6, 1'b1};
    vecs[5] = '{4'b0001, 4'b0001, 4'b1111, 0, 4'b0000, 2, 1'b0};
`else
    vecs[0] = '{4'b1010, 4'b1010, 4'b0000, 0, 4'b0000, 2, 1'b0};
    vecs[1] = '{4'b0110, 4'b0100, 4'b1000, 0, 4'b0000, 2, 1'b0};
    vecs[2] = '{4'b0110, 4'b0000, 4'b0000, 0, 4'b0000, 2, 1'b0};
    vecs[3] = '{4'b1000, 4'b1000, 4'b0110, 1, 4'b0000, 4, 1'b0};
    vecs[4] = '{4'b0001, 4'b0001, 4'b1000, 0, 4'b0001, 6, 1'b1};
    vecs[5] = '{4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, 2, 1'b0};
`endif
    bus.start  = 1'b0;
    bus.target = 4'b0000;

    // Reset state
    #12;
    chk("rst_J", 32'(bus.J), 32'h0);
    chk("rst_K", 32'(bus.K), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    @(negedge CLK);
    CLR = 1'b1;

    for (int v = 0; v < 6; v++) begin
      @(negedge CLK);
      skip_until = drive_cnt + vecs[v].skip;
      stuck      = vecs[v].stuck;
      bus.start  = 1'b1;
      bus.target = vecs[v].target;
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
      chk($sformatf("v%0d_J", v), 32'(bus.J), 32'(vecs[v].exp_j));
      chk($sformatf("v%0d_K", v), 32'(bus.K), 32'(vecs[v].exp_k));
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'h1);
      chk($sformatf("v%0d_err_clear", v), 32'(bus.err), 32'h0);
      lat = 0;
      while (lat < 20 && !bus.done && !bus.err) begin
        @(posedge CLK);
        #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_done", v), 32'(bus.done), 32'(!vecs[v].exp_err));
      chk($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'h0);
      if (!vecs[v].exp_err) chk($sformatf("v%0d_q", v), 32'(bus.q_fb), 32'(vecs[v].target));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_done_pulse", v), 32'(bus.done), 32'h0);
      chk($sformatf("v%0d_err_hold", v), 32'(bus.err), 32'(vecs[v].exp_err));

      // After the first transaction, abort a new drive with CLR mid-DRIVE.
      if (v == 0) begin
        @(negedge CLK);
        bus.start  = 1'b1;
        bus.target = 4'b0101;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        chk("abort_busy_before", 32'(bus.busy), 32'h1);
        #2;
        CLR = 1'b0;
        #1;
        chk("abort_J", 32'(bus.J), 32'h0);
        chk("abort_K", 32'(bus.K), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_q_held", 32'(bus.q_fb), 32'hA);
        chk("abort_idle", 32'(bus.busy), 32'h0);
      end
    end

    // start during busy with target=1111 must be ignored
    @(negedge CLK);
    bus.start  = 1'b1;
    bus.target = 4'b0000;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
`ifdef JK_TOGGLE_EXCITE_EN
    chk("busy_ign_J", 32'(bus.J), 32'h1);
    chk("busy_ign_K", 32'(bus.K), 32'hF);
`else
    chk("busy_ign_J", 32'(bus.J), 32'h0);
    chk("busy_ign_K", 32'(bus.K), 32'h1);
`endif
    @(negedge CLK);
    bus.start  = 1'b1;
    bus.target = 4'b1111;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    chk("busy_ign_J_check", 32'(bus.J), 32'h0);
    done_cnt = 0;
    done_at  = 0;
    for (int c = 2; c < 8; c++) begin
      @(posedge CLK);
      #1;
      if (bus.done) begin
        done_cnt++;
        done_at = c;
      end
    end
    chk("busy_ign_done_count", 32'(done_cnt), 32'h1);
    chk("busy_ign_done_at", 32'(done_at), 32'h2);
    chk("busy_ign_q", 32'(bus.q_fb), 32'h0);
    chk("busy_ign_idle", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
